// File: rtl/arbitro_wrr_pkg.sv
// arbitro_wrr shared definitions
// FSM encoding, flit field positions, finder result bundle
package arbitro_wrr_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CARGA = 2'd1;
  localparam logic [1:0] ST_ARB   = 2'd2;

  localparam int N_CLS = 4;

  localparam int DEST_HI = 9;
  localparam int DEST_LO = 8;
  localparam int DEST_W  = DEST_HI - DEST_LO + 1;

  localparam int CLASS_HI = 11;
  localparam int CLASS_LO = 10;
  localparam int CLS_W    = CLASS_HI - CLASS_LO + 1;

  typedef struct packed {
    logic             hit;
    logic [CLS_W-1:0] cls;
  } busca_t;

  function automatic logic [N_CLS-1:0] onehot4(
    input logic [CLS_W-1:0] k
  );
    onehot4 = 4'b0001 << k;
  endfunction

endpackage

// File: rtl/arbitro_wrr_rr_busca.sv
// Round-robin first-eligible finder
// Scans req starting at start, wrapping mod 4
module rr_busca
  import arbitro_wrr_pkg::*;
(
  input  logic [N_CLS-1:0] req,
  input  logic [CLS_W-1:0] start,
  output logic             found,
  output logic [CLS_W-1:0] idx
);

  logic [CLS_W-1:0] k;

  // walk offsets high to low so the nearest hit wins
  always_comb begin
    found = 1'b0;
    idx   = start;
    k     = start;
    for (int i = N_CLS - 1; i >= 0; i--) begin
      k = start + CLS_W'(i);
      if (req[k]) begin
        found = 1'b1;
        idx   = k;
      end
    end
  end

endmodule

// File: rtl/arbitro_wrr.sv
// Weighted round-robin pop scheduler
// Feeds fifoin2 from class FIFOs fifo0..fifo3
module arbitro_wrr
  import arbitro_wrr_pkg::*;
#(
  parameter int PESO_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [4*PESO_W-1:0]   peso,
  input  logic [3:0]            empty,
  input  logic [7:0]            head_dest,
  input  logic [3:0]            almost_full_dest,
  input  logic                  almost_full_in2,
  input  logic [1:0]            idx,
  output logic [3:0]            pop,
  output logic [1:0]            sel,
  output logic                  valid,
  output logic [CNT_W-1:0]      grant_cnt,
  output logic                  idle
);

  logic [1:0]        state;
  logic [PESO_W-1:0] wreg [N_CLS];
  logic [CNT_W-1:0]  cnt  [N_CLS];
  logic [CLS_W-1:0]  ptr;
  logic [PESO_W-1:0] credit;

  logic [N_CLS-1:0]  elig;
  logic [N_CLS-1:0]  req_oth;
  logic [CLS_W-1:0]  ptr_nx;
  busca_t            fnd;
  logic              in_arb;
  logic              stay;
  logic              grant;
  logic [CLS_W-1:0]  g;
  logic [CLS_W-1:0]  g_nx;
  logic [PESO_W-1:0] cred_nx;

  // class eligibility: data, weight, dest room, global room
  always_comb begin
    elig = '0;
    for (int k = 0; k < N_CLS; k++) begin
      elig[k] = !empty[k]
        && (wreg[k] != '0)
        && !almost_full_dest[head_dest[DEST_W*k +: DEST_W]]
        && !almost_full_in2;
    end
  end

  assign in_arb  = (state == ST_ARB) && !init;
  assign ptr_nx  = ptr + CLS_W'(1);
  assign req_oth = elig & ~onehot4(ptr);

  rr_busca u_busca (
    .req   (req_oth),
    .start (ptr_nx),
    .found (fnd.hit),
    .idx   (fnd.cls)
  );

  // pick ptr while it has credit, else next eligible
  always_comb begin
    stay    = elig[ptr] && (credit != '0);
    grant   = in_arb && (stay || fnd.hit);
    g       = stay ? ptr : fnd.cls;
    g_nx    = g + CLS_W'(1);
    cred_nx = stay ? credit - PESO_W'(1)
                   : wreg[g] - PESO_W'(1);
  end

  assign pop       = grant ? onehot4(g) : '0;
  assign grant_cnt = cnt[idx];
  assign idle      = (state == ST_IDLE)
                  || ((state == ST_ARB) && (elig == '0));

  // control FSM: idle, one load cycle, arbitrate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      unique case (1'b1)
        state == ST_IDLE:  if (init) state <= ST_CARGA;
        state == ST_CARGA: state <= ST_ARB;
        state == ST_ARB:   if (init) state <= ST_CARGA;
        default:           state <= ST_IDLE;
      endcase
    end
  end

  // weight registers latched on the load cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_CLS; k++) wreg[k] <= '0;
    end else if (state == ST_CARGA) begin
      for (int k = 0; k < N_CLS; k++)
        wreg[k] <= peso[k*PESO_W +: PESO_W];
    end
  end

  // turn pointer and remaining credit of the current class
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr    <= '0;
      credit <= '0;
    end else if (state == ST_CARGA) begin
      ptr    <= '0;
      credit <= peso[PESO_W-1:0];
    end else if (grant) begin
      if (cred_nx == '0) begin
        ptr    <= g_nx;
        credit <= wreg[g_nx];
      end else begin
        ptr    <= g;
        credit <= cred_nx;
      end
    end
  end

  // saturating per-class grant counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N_CLS; k++) cnt[k] <= '0;
    end else if (state == ST_CARGA) begin
      for (int k = 0; k < N_CLS; k++) cnt[k] <= '0;
    end else if (grant && (cnt[g] != '1)) begin
      cnt[g] <= cnt[g] + CNT_W'(1);
    end
  end

  // delayed mux select and fifoin2 write enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      sel   <= '0;
    end else begin
      valid <= grant;
      if (grant) sel <= g;
    end
  end

endmodule

// File: tb/tb_arbitro_wrr.sv
// Self-checking bench for arbitro_wrr
// Directed scenarios plus randomized run against a reference model
module tb_arbitro_wrr;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [11:0] peso;
  logic [3:0]  empty;
  logic [7:0]  head_dest;
  logic [3:0]  afd;
  logic        af2;
  logic [1:0]  idx;
  logic [3:0]  pop;
  logic [1:0]  sel;
  logic        valid;
  logic [7:0]  grant_cnt;
  logic        idle;

  int checks   = 0;
  int failures = 0;

  arbitro_wrr #(.PESO_W(3), .CNT_W(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .init             (init),
    .peso             (peso),
    .empty            (empty),
    .head_dest        (head_dest),
    .almost_full_dest (afd),
    .almost_full_in2  (af2),
    .idx              (idx),
    .pop              (pop),
    .sel              (sel),
    .valid            (valid),
    .grant_cnt        (grant_cnt),
    .idle             (idle)
  );

  always #5 clk = ~clk;

  // reference model: 0 idle, 1 load, 2 arbitrate
  int   m_st, m_ptr, m_cred, m_sel;
  bit   m_valid;
  int   m_w [4];
  int   m_cnt [4];
  bit   e_grant, e_stay, e_idle;
  int   e_g;
  logic [3:0] e_pop;

  function automatic void model_reset();
    m_st = 0; m_ptr = 0; m_cred = 0;
    m_sel = 0; m_valid = 0;
    for (int k = 0; k < 4; k++) begin
      m_w[k] = 0; m_cnt[k] = 0;
    end
  endfunction

  function automatic void model_eval();
    bit el [4];
    bit any;
    any = 0;
    for (int k = 0; k < 4; k++) begin
      el[k] = !empty[k] && m_w[k] != 0
           && !afd[head_dest[2*k +: 2]] && !af2;
      any |= el[k];
    end
    e_grant = 0; e_stay = 0; e_g = 0;
    if (m_st == 2 && !init) begin
      if (el[m_ptr] && m_cred > 0) begin
        e_grant = 1; e_stay = 1; e_g = m_ptr;
      end else begin
        for (int o = 1; o < 4; o++)
          if (!e_grant && el[(m_ptr + o) % 4]) begin
            e_grant = 1; e_g = (m_ptr + o) % 4;
          end
      end
    end
    e_pop  = e_grant ? 4'(1 << e_g) : 4'b0000;
    e_idle = (m_st == 0) || (m_st == 2 && !any);
  endfunction

  function automatic void model_commit();
    int nc;
    if (reset !== 1'b1) begin
      model_reset();
      return;
    end
    m_valid = e_grant;
    if (e_grant) m_sel = e_g;
    case (m_st)
      0: if (init) m_st = 1;
      1: begin
        for (int k = 0; k < 4; k++) begin
          m_w[k] = int'(peso[3*k +: 3]);
          m_cnt[k] = 0;
        end
        m_ptr = 0; m_cred = m_w[0]; m_st = 2;
      end
      default: begin
        if (init) m_st = 1;
        else if (e_grant) begin
          if (m_cnt[e_g] < 255) m_cnt[e_g]++;
          nc = e_stay ? m_cred - 1 : m_w[e_g] - 1;
          if (nc == 0) begin
            m_ptr = (e_g + 1) % 4;
            m_cred = m_w[m_ptr];
          end else begin
            m_ptr = e_g; m_cred = nc;
          end
        end
      end
    endcase
  endfunction

  // advance one clock; returns at negedge+1
  task automatic next_cycle();
    model_eval();
    model_commit();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [11:0] p);
    peso = p; init = 1'b1;
    next_cycle();
    init = 1'b0;
    next_cycle();
  endtask

  task automatic quiet();
    empty = 4'h0; head_dest = 8'h00;
    afd = 4'h0; af2 = 1'b0; idx = 2'd0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    model_reset();
    #1;
    checks++;
    if (pop !== 4'b0 || valid !== 1'b0 || sel !== 2'd0
        || idle !== 1'b1 || grant_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset got pop=%b v=%b s=%0d i=%b c=%0d exp 0000/0/0/1/0",
               pop, valid, sel, idle, grant_cnt);
    end
    next_cycle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (pop !== 4'b0 || idle !== 1'b1) begin
        failures++;
        $display("FAIL idle_no_init c=%0d got pop=%b idle=%b exp 0000/1",
                 i, pop, idle);
      end
      next_cycle();
    end
  endtask

  task automatic test_wrr_seq();
    int ex [9] = '{0, 0, 1, 2, 3, 0, 0, 1, 2};
    quiet();
    start({3'd1, 3'd1, 3'd1, 3'd2});
    for (int i = 0; i < 9; i++) begin
      #1; checks++;
      if (pop !== 4'(1 << ex[i])) begin
        failures++;
        $display("FAIL wrr_pop c=%0d got=%b exp=%b",
                 i, pop, 4'(1 << ex[i]));
      end
      checks++;
      if (valid !== (i > 0)
          || (i > 0 && sel !== 2'(ex[i > 0 ? i - 1 : 0]))) begin
        failures++;
        $display("FAIL wrr_valid c=%0d got v=%b s=%0d", i, valid, sel);
      end
      next_cycle();
    end
  endtask

  task automatic test_single();
    quiet();
    empty = 4'b1011;
    start({3'd1, 3'd1, 3'd1, 3'd1});
    for (int i = 0; i < 5; i++) begin
      #1; checks++;
      if (pop !== 4'b0100 || idle !== 1'b0) begin
        failures++;
        $display("FAIL single_pop c=%0d got pop=%b idle=%b exp 0100/0",
                 i, pop, idle);
      end
      next_cycle();
    end
    empty = 4'hF;
    #1; checks++;
    if (pop !== 4'b0 || idle !== 1'b1 || valid !== 1'b1
        || sel !== 2'd2) begin
      failures++;
      $display("FAIL single_drain got pop=%b i=%b v=%b s=%0d exp 0000/1/1/2",
               pop, idle, valid, sel);
    end
    next_cycle();
    #1; checks++;
    if (valid !== 1'b0 || pop !== 4'b0) begin
      failures++;
      $display("FAIL single_after got v=%b pop=%b exp 0/0000",
               valid, pop);
    end
    next_cycle();
  endtask

  task automatic test_skip();
    int ex [13] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
    quiet();
    head_dest = 8'h02;
    afd = 4'b0100;
    start({3'd3, 3'd3, 3'd3, 3'd3});
    for (int i = 0; i < 13; i++) begin
      if (i == 9) afd = 4'b0000;
      #1; checks++;
      if (pop !== 4'(1 << ex[i])) begin
        failures++;
        $display("FAIL skip_pop c=%0d got=%b exp=%b",
                 i, pop, 4'(1 << ex[i]));
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    int ex [11] = '{0, 0, 1, -1, -1, -1, -1, 2, 3, 0, 0};
    int pv;
    quiet();
    start({3'd1, 3'd1, 3'd1, 3'd2});
    for (int i = 0; i < 11; i++) begin
      af2 = (ex[i] < 0);
      pv = (i > 0) ? ex[i-1] : -1;
      #1; checks++;
      if (pop !== (ex[i] < 0 ? 4'b0 : 4'(1 << ex[i]))) begin
        failures++;
        $display("FAIL stall_pop c=%0d got=%b exp_cls=%0d",
                 i, pop, ex[i]);
      end
      checks++;
      if (valid !== (pv >= 0) || (pv >= 0 && sel !== 2'(pv))) begin
        failures++;
        $display("FAIL stall_valid c=%0d got v=%b s=%0d exp_cls=%0d",
                 i, valid, sel, pv);
      end
      next_cycle();
    end
    af2 = 1'b0;
  endtask

  task automatic test_zero_weight();
    int ex [6] = '{0, 2, 3, 0, 2, 3};
    int ec [4] = '{2, 0, 2, 2};
    quiet();
    start({3'd1, 3'd1, 3'd0, 3'd1});
    for (int i = 0; i < 6; i++) begin
      #1; checks++;
      if (pop !== 4'(1 << ex[i])) begin
        failures++;
        $display("FAIL zw_pop c=%0d got=%b exp=%b",
                 i, pop, 4'(1 << ex[i]));
      end
      next_cycle();
    end
    empty = 4'hF;
    for (int i = 0; i < 4; i++) begin
      idx = 2'(i);
      #1; checks++;
      if (grant_cnt !== 8'(ec[i])) begin
        failures++;
        $display("FAIL zw_cnt idx=%0d got=%0d exp=%0d",
                 i, grant_cnt, ec[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_all_zero();
    quiet();
    start(12'h000);
    for (int i = 0; i < 4; i++) begin
      #1; checks++;
      if (pop !== 4'b0 || idle !== 1'b1) begin
        failures++;
        $display("FAIL allzero c=%0d got pop=%b idle=%b exp 0000/1",
                 i, pop, idle);
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    quiet();
    start({3'd1, 3'd1, 3'd1, 3'd1});
    for (int i = 0; i < 3; i++) next_cycle();
    #1; checks++;
    if (valid !== 1'b1 || pop === 4'b0) begin
      failures++;
      $display("FAIL arst_pre got v=%b pop=%b exp 1/nonzero",
               valid, pop);
    end
    reset = 1'b0;
    model_reset();
    #1; checks++;
    if (pop !== 4'b0 || valid !== 1'b0 || idle !== 1'b1) begin
      failures++;
      $display("FAIL arst_now got pop=%b v=%b i=%b exp 0000/0/1",
               pop, valid, idle);
    end
    next_cycle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (pop !== 4'b0 || valid !== 1'b0 || idle !== 1'b1) begin
        failures++;
        $display("FAIL arst_post c=%0d got pop=%b v=%b i=%b exp 0000/0/1",
                 i, pop, valid, idle);
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    quiet();
    start(12'($urandom));
    for (int c = 0; c < 800; c++) begin
      init = ($urandom_range(0, 39) == 0);
      if (init) peso = 12'($urandom);
      for (int k = 0; k < 4; k++) begin
        empty[k] = ($urandom_range(0, 3) == 0);
        afd[k]   = ($urandom_range(0, 4) == 0);
      end
      head_dest = 8'($urandom);
      af2 = ($urandom_range(0, 9) == 0);
      idx = 2'($urandom);
      #1;
      model_eval();
      checks++;
      if (pop !== e_pop || idle !== e_idle) begin
        failures++;
        $display("FAIL rnd_pop c=%0d got pop=%b idle=%b exp %b/%b",
                 c, pop, idle, e_pop, e_idle);
      end
      checks++;
      if (valid !== m_valid || sel !== 2'(m_sel)) begin
        failures++;
        $display("FAIL rnd_valid c=%0d got v=%b s=%0d exp %b/%0d",
                 c, valid, sel, m_valid, m_sel);
      end
      checks++;
      if (grant_cnt !== 8'(m_cnt[idx])) begin
        failures++;
        $display("FAIL rnd_cnt c=%0d idx=%0d got=%0d exp=%0d",
                 c, idx, grant_cnt, m_cnt[idx]);
      end
      next_cycle();
    end
    init = 1'b0;
  endtask

  initial begin
    reset = 1'b0; init = 1'b0; peso = 12'h000;
    quiet();
    model_reset();
    test_reset();
    test_wrr_seq();
    test_single();
    test_skip();
    test_stall();
    test_zero_weight();
    test_all_zero();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
